// File: rtl/qspi_boot_ctrl.sv
// qspi_boot_ctrl: copies WORDS 32-bit words from SPI flash (READ 0x03, mode 0, single bit on
// DQ0/DQ1) into memory through a req/gnt write port, then hands the QSPI pads to the SoC SPI
// master and lets fetch enable through to the core.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   enable_i                       start permission, sampled only while idle
//   fetch_en_i / fetch_en_o        fetch-enable request in, gated by done_o out
//   busy_o, done_o                 copy in progress / copy finished (sticky)
//   mem_req_o, mem_addr_o,
//   mem_wdata_o, mem_gnt_i         memory write port
//   m_clk_i, m_csn_i, m_sdo_i,
//   m_oen_i, m_sdi_o               SoC SPI master side
//   qspi_clk_o, qspi_csn_o,
//   qspi_sdo_o, qspi_oen_o,
//   qspi_sdi_i                     pad side (oen=1 means high-Z)
`timescale 1ns/1ps
module qspi_boot_ctrl #(
    parameter int unsigned CLK_DIV    = 2,
    parameter logic [23:0] FLASH_ADDR = 24'h000000,
    parameter int unsigned WORDS      = 8192,
    parameter logic [31:0] MEM_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic        fetch_en_i,
    output logic        fetch_en_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        m_clk_i,
    input  logic        m_csn_i,
    input  logic [3:0]  m_sdo_i,
    input  logic [3:0]  m_oen_i,
    output logic [3:0]  m_sdi_o,
    output logic        qspi_clk_o,
    output logic        qspi_csn_o,
    output logic [3:0]  qspi_sdo_o,
    output logic [3:0]  qspi_oen_o,
    input  logic [3:0]  qspi_sdi_i
);

    localparam int unsigned      DivW    = $clog2(CLK_DIV + 1);
    localparam int unsigned      CntW    = $clog2(WORDS + 1);
    localparam logic [DivW-1:0]  DivLast = DivW'(CLK_DIV - 1);
    localparam logic [CntW-1:0]  WordsN  = CntW'(WORDS);
    localparam logic [31:0]      TxInit  = {8'h03, FLASH_ADDR};

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StWrite, StDone} state_e;

    state_e          state_q, state_d;
    logic            sck_q, sck_d;
    logic            csn_q, csn_d;
    logic            sdo_q, sdo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            req_q, req_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     tx_q, tx_d;
    logic [31:0]     rx_q, rx_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [CntW-1:0] word_cnt_q, word_cnt_d;

    logic        shifting, fall, sample;
    logic [31:0] rx_next;

    always_comb begin
        shifting = state_q inside {StCmd, StAddr, StData};
        fall     = shifting && sck_q && (div_cnt_q == DivLast);
        // MISO is taken in the first cycle of the high phase.
        sample   = (state_q == StData) && sck_q && (div_cnt_q == '0);
        rx_next  = sample ? {rx_q[30:0], qspi_sdi_i[1]} : rx_q;
    end

    always_comb begin
        state_d    = state_q;
        sck_d      = sck_q;
        csn_d      = csn_q;
        sdo_d      = sdo_q;
        busy_d     = busy_q;
        done_d     = done_q;
        req_d      = req_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_d       = tx_q;
        rx_d       = rx_next;
        bit_cnt_d  = bit_cnt_q;
        div_cnt_d  = div_cnt_q;
        word_cnt_d = word_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d    = StCmd;
                    csn_d      = 1'b0;
                    busy_d     = 1'b1;
                    sck_d      = 1'b0;
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    tx_d       = TxInit;
                    sdo_d      = TxInit[31];
                    addr_d     = MEM_BASE;
                    word_cnt_d = '0;
                end
            end
            StCmd, StAddr, StData: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    sck_d     = ~sck_q;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    tx_d      = {tx_q[30:0], 1'b0};
                    sdo_d     = tx_q[30];
                    if (state_q == StCmd && bit_cnt_q == 5'd7) begin
                        state_d   = StAddr;
                        bit_cnt_d = '0;
                    end else if (state_q == StAddr && bit_cnt_q == 5'd23) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                        sdo_d     = 1'b0;
                    end else if (state_q == StData) begin
                        sdo_d = 1'b0;
                        if (bit_cnt_q == 5'd31) begin
                            state_d   = StWrite;
                            bit_cnt_d = '0;
                            req_d     = 1'b1;
                            // First flash byte arrived first, so it sits in rx[31:24].
                            wdata_d   = {rx_next[7:0], rx_next[15:8], rx_next[23:16],
                                         rx_next[31:24]};
                        end
                    end
                end
            end
            StWrite: begin
                if (mem_gnt_i) begin
                    req_d      = 1'b0;
                    addr_d     = addr_q + 32'd4;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_d == WordsN) begin
                        state_d = StDone;
                        csn_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // CSN stays low: the flash keeps streaming the next word.
                        state_d   = StData;
                        sck_d     = 1'b0;
                        div_cnt_d = '0;
                        bit_cnt_d = '0;
                    end
                end
            end
            StDone: begin
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sck_q      <= 1'b0;
            csn_q      <= 1'b1;
            sdo_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= MEM_BASE;
            wdata_q    <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
            div_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sck_q      <= sck_d;
            csn_q      <= csn_d;
            sdo_q      <= sdo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_cnt_q  <= bit_cnt_d;
            div_cnt_q  <= div_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Pad mux: the block owns the pads until done, then it is a plain pass-through.
    always_comb begin
        qspi_clk_o = done_q ? m_clk_i : sck_q;
        qspi_csn_o = done_q ? m_csn_i : csn_q;
        qspi_sdo_o = done_q ? m_sdo_i : {3'b000, sdo_q};
        qspi_oen_o = done_q ? m_oen_i : (busy_q ? 4'b1110 : 4'b1111);
        m_sdi_o    = done_q ? qspi_sdi_i : 4'b0000;
    end

    assign fetch_en_o  = done_q & fetch_en_i;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign mem_req_o   = req_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_qspi_boot_ctrl.sv
`timescale 1ns/1ps
module tb_qspi_boot_ctrl;

    localparam int unsigned A_DIV   = 2;
    localparam int unsigned A_WORDS = 4;
    localparam logic [23:0] A_FADDR = 24'hA53C0F;
    localparam logic [31:0] A_BASE  = 32'h2000_0100;
    localparam int unsigned B_DIV   = 1;
    localparam int unsigned B_WORDS = 1;
    localparam logic [23:0] B_FADDR = 24'h000010;
    localparam logic [31:0] B_BASE  = 32'h0000_8000;
    localparam int          CLK_PER = 10;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #(CLK_PER / 2) clk = ~clk;

    logic [7:0] flash_byte [16] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                                    8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};

    logic        m_clk = 1'b0, m_csn = 1'b1;
    logic [3:0]  m_sdo = 4'h0, m_oen = 4'hF;

    logic        a_en = 1'b0, a_fe_i = 1'b0, a_gnt = 1'b0, a_sdi_ovr = 1'b0;
    logic        a_fe_o, a_busy, a_done, a_req, a_sck, a_csn;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_msdi, a_sdo, a_oen, a_sdi;

    logic        b_en = 1'b0, b_fe_i = 1'b0, b_gnt = 1'b0;
    logic        b_fe_o, b_busy, b_done, b_req, b_sck, b_csn;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_msdi, b_sdo, b_oen, b_sdi;

    qspi_boot_ctrl #(.CLK_DIV(A_DIV), .FLASH_ADDR(A_FADDR), .WORDS(A_WORDS), .MEM_BASE(A_BASE))
    dut_a (
        .clk(clk), .rst_n(rst_n), .enable_i(a_en), .fetch_en_i(a_fe_i), .fetch_en_o(a_fe_o),
        .busy_o(a_busy), .done_o(a_done), .mem_req_o(a_req), .mem_addr_o(a_addr),
        .mem_wdata_o(a_wdata), .mem_gnt_i(a_gnt), .m_clk_i(m_clk), .m_csn_i(m_csn),
        .m_sdo_i(m_sdo), .m_oen_i(m_oen), .m_sdi_o(a_msdi), .qspi_clk_o(a_sck),
        .qspi_csn_o(a_csn), .qspi_sdo_o(a_sdo), .qspi_oen_o(a_oen), .qspi_sdi_i(a_sdi)
    );

    qspi_boot_ctrl #(.CLK_DIV(B_DIV), .FLASH_ADDR(B_FADDR), .WORDS(B_WORDS), .MEM_BASE(B_BASE))
    dut_b (
        .clk(clk), .rst_n(rst_n), .enable_i(b_en), .fetch_en_i(b_fe_i), .fetch_en_o(b_fe_o),
        .busy_o(b_busy), .done_o(b_done), .mem_req_o(b_req), .mem_addr_o(b_addr),
        .mem_wdata_o(b_wdata), .mem_gnt_i(b_gnt), .m_clk_i(m_clk), .m_csn_i(m_csn),
        .m_sdo_i(m_sdo), .m_oen_i(m_oen), .m_sdi_o(b_msdi), .qspi_clk_o(b_sck),
        .qspi_csn_o(b_csn), .qspi_sdo_o(b_sdo), .qspi_oen_o(b_oen), .qspi_sdi_i(b_sdi)
    );

    // Mode-0 flash model per DUT: captures cmd+addr on SCK rise, shifts data on SCK fall.
    for (genvar g = 0; g < 2; g++) begin : g_fm
        wire lsck  = (g == 0) ? a_sck : b_sck;
        wire lcsn  = (g == 0) ? a_csn : b_csn;
        wire lmosi = (g == 0) ? a_sdo[0] : b_sdo[0];
        localparam int Per = CLK_PER * 2 * ((g == 0) ? A_DIV : B_DIV);
        int          bits = 0;
        int          hdr_cnt = 0;
        int          per_err = 0;
        logic [31:0] hdr = '0;
        logic [31:0] hdr_seen = '0;
        time         last_rise = 0;
        logic        miso = 1'b1;
        always @(negedge lcsn) bits = 0;
        always @(posedge lsck) begin
            if (!lcsn) begin
                if (bits >= 1 && bits < 32 && ($time - last_rise) != Per) per_err++;
                last_rise = $time;
                if (bits < 32) hdr = {hdr[30:0], lmosi};
                bits++;
                if (bits == 32) begin
                    hdr_seen = hdr;
                    hdr_cnt++;
                end
            end
        end
        always @(negedge lsck) begin
            if (!lcsn && bits >= 32) begin
                int idx;
                idx  = bits - 32;
                miso = flash_byte[(idx / 8) % 16][7 - (idx % 8)];
            end
        end
    end

    // DQ0/DQ2/DQ3 read back high (pull-ups); DQ1 is the flash MISO.
    assign a_sdi = a_sdi_ovr ? 4'h5 : {2'b11, g_fm[0].miso, 1'b1};
    assign b_sdi = {2'b11, g_fm[1].miso, 1'b1};

    // Memory responder and protocol monitors for dut_a.
    int          a_gnt_delay = 0;
    logic        a_junk_gnt = 1'b0;
    int          a_wait = 0, a_first_len = 0;
    int          a_stab_err = 0, a_csn_gap = 0, a_fe_err = 0, a_msdi_err = 0;
    logic [31:0] a_hold_addr = '0, a_hold_data = '0;
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    always @(negedge clk) begin
        if (a_busy && a_csn) a_csn_gap++;
        if (a_fe_o && !a_done) a_fe_err++;
        if (!a_done && a_msdi !== 4'h0) a_msdi_err++;
        if (a_req) begin
            if (a_sck !== 1'b0 || a_csn !== 1'b0) a_stab_err++;
            if (a_wait == 0) begin
                a_hold_addr = a_addr;
                a_hold_data = a_wdata;
            end else if (a_addr !== a_hold_addr || a_wdata !== a_hold_data) begin
                a_stab_err++;
            end
            if (a_wait >= a_gnt_delay) begin
                a_gnt = 1'b1;
                wr_addr_q.push_back(a_addr);
                wr_data_q.push_back(a_wdata);
                if (wr_addr_q.size() == 1) a_first_len = a_wait + 1;
                a_wait = 0;
            end else begin
                a_gnt = 1'b0;
                a_wait++;
            end
        end else begin
            a_gnt  = a_junk_gnt;
            a_wait = 0;
        end
    end

    task automatic test_reset();
        rst_n  = 1'b0;
        a_fe_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (a_csn !== 1'b1) begin errors++; $display("FAIL reset_csn got %b want 1", a_csn); end
        checks++; if (a_sck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", a_sck); end
        checks++; if (a_sdo !== 4'h0) begin errors++; $display("FAIL reset_sdo got %h want 0", a_sdo); end
        checks++; if (a_oen !== 4'hF) begin errors++; $display("FAIL reset_oen got %h want f", a_oen); end
        checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", a_req); end
        checks++; if (a_addr !== A_BASE) begin errors++; $display("FAIL reset_addr got %h want %h", a_addr, A_BASE); end
        checks++; if (a_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", a_wdata); end
        checks++; if ({a_busy, a_done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b want 00", {a_busy, a_done}); end
        checks++; if (a_fe_o !== 1'b0) begin errors++; $display("FAIL reset_fetch_en got %b want 0", a_fe_o); end
        checks++; if (a_msdi !== 4'h0) begin errors++; $display("FAIL reset_m_sdi got %h want 0", a_msdi); end
        checks++; if (b_addr !== B_BASE) begin errors++; $display("FAIL reset_b_addr got %h want %h", b_addr, B_BASE); end
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if ({a_csn, a_busy} !== 2'b10) begin errors++; $display("FAIL idle_hold got csn,busy=%b want 10", {a_csn, a_busy}); end
    endtask

    // Request is expected in cycle 129 counting the first CSN-low cycle as cycle 1,
    // i.e. visible right after the 128th clock edge following the start edge.
    task automatic test_clkdiv1();
        int n;
        @(negedge clk) b_en = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({b_csn, b_busy} !== 2'b01) begin errors++; $display("FAIL b_start got csn,busy=%b want 01", {b_csn, b_busy}); end
        checks++; if (b_sdo !== 4'h0 || b_oen !== 4'hE) begin errors++; $display("FAIL b_start_pads got sdo=%h oen=%h want 0 e", b_sdo, b_oen); end
        @(negedge clk) b_en = 1'b0;
        n = 0;
        while (b_req !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != 128) begin errors++; $display("FAIL b_req_latency got %0d want 128", n); end
        checks++; if (b_addr !== B_BASE) begin errors++; $display("FAIL b_addr got %h want %h", b_addr, B_BASE); end
        checks++; if (b_wdata !== 32'h44332211) begin errors++; $display("FAIL b_wdata got %h want 44332211", b_wdata); end
        checks++; if (g_fm[1].hdr_seen !== {8'h03, B_FADDR}) begin errors++; $display("FAIL b_header got %h want %h", g_fm[1].hdr_seen, {8'h03, B_FADDR}); end
        checks++; if (g_fm[1].per_err != 0) begin errors++; $display("FAIL b_sck_period got %0d bad periods want 0", g_fm[1].per_err); end
        @(negedge clk) b_gnt = 1'b1;
        @(posedge clk);
        #1 b_gnt = 1'b0;
        checks++; if ({b_done, b_busy, b_req} !== 3'b100) begin errors++; $display("FAIL b_done got done,busy,req=%b want 100", {b_done, b_busy, b_req}); end
        checks++; if (b_addr !== B_BASE + 32'd4) begin errors++; $display("FAIL b_addr_inc got %h want %h", b_addr, B_BASE + 32'd4); end
    endtask

    task automatic test_restart();
        int n;
        wr_addr_q.delete();
        wr_data_q.delete();
        a_gnt_delay = 0;
        @(negedge clk) a_en = 1'b1;
        n = 0;
        while (wr_addr_q.size() < 3 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checks++; if (wr_addr_q.size() < 3) begin errors++; $display("FAIL restart_three_words got %0d writes want 3", wr_addr_q.size()); end
        repeat (40) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({a_csn, a_req, a_busy} !== 3'b100) begin errors++; $display("FAIL async_reset got csn,req,busy=%b want 100", {a_csn, a_req, a_busy}); end
        checks++; if (a_addr !== A_BASE) begin errors++; $display("FAIL async_reset_addr got %h want %h", a_addr, A_BASE); end
        if (wr_addr_q.size() >= 3) begin
            checks++; if (wr_data_q[2] !== 32'hCCBBAA99) begin errors++; $display("FAIL restart_word2 got %h want ccbbaa99", wr_data_q[2]); end
            checks++; if (wr_addr_q[2] !== A_BASE + 32'd8) begin errors++; $display("FAIL restart_addr2 got %h want %h", wr_addr_q[2], A_BASE + 32'd8); end
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        a_gnt_delay = 5;
        a_junk_gnt  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_copy(input int hdr_base);
        logic [31:0] exp_data [4] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};
        int n;
        n = 0;
        while (wr_addr_q.size() < 1 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        a_gnt_delay = 0;
        while (a_done !== 1'b1 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL copy_done got %b want 1 (timeout)", a_done); end
        checks++; if (wr_addr_q.size() != 4) begin errors++; $display("FAIL copy_count got %0d want 4", wr_addr_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr_q.size()) begin
                checks++; if (wr_addr_q[i] !== A_BASE + 32'(4 * i)) begin errors++; $display("FAIL copy_addr%0d got %h want %h", i, wr_addr_q[i], A_BASE + 32'(4 * i)); end
                checks++; if (wr_data_q[i] !== exp_data[i]) begin errors++; $display("FAIL copy_data%0d got %h want %h", i, wr_data_q[i], exp_data[i]); end
            end
        end
        checks++; if (a_first_len != 6) begin errors++; $display("FAIL gnt_wait_len got %0d want 6", a_first_len); end
        checks++; if (a_stab_err != 0) begin errors++; $display("FAIL req_stable got %0d errors want 0", a_stab_err); end
        checks++; if (a_csn_gap != 0) begin errors++; $display("FAIL csn_continuous got %0d gaps want 0", a_csn_gap); end
        checks++; if (g_fm[0].hdr_cnt != hdr_base + 1) begin errors++; $display("FAIL restart_header_count got %0d want %0d", g_fm[0].hdr_cnt, hdr_base + 1); end
        checks++; if (g_fm[0].hdr_seen !== {8'h03, A_FADDR}) begin errors++; $display("FAIL a_header got %h want %h", g_fm[0].hdr_seen, {8'h03, A_FADDR}); end
        checks++; if (g_fm[0].per_err != 0) begin errors++; $display("FAIL a_sck_period got %0d bad periods want 0", g_fm[0].per_err); end
        checks++; if ({a_busy, a_req} !== 2'b00) begin errors++; $display("FAIL a_idle_after got busy,req=%b want 00", {a_busy, a_req}); end
        checks++; if (a_msdi_err != 0) begin errors++; $display("FAIL m_sdi_during_boot got %0d errors want 0", a_msdi_err); end
    endtask

    task automatic test_fetch_en();
        checks++; if (a_fe_err != 0) begin errors++; $display("FAIL fetch_en_early got %0d errors want 0", a_fe_err); end
        checks++; if (a_fe_o !== 1'b1) begin errors++; $display("FAIL fetch_en_after got %b want 1", a_fe_o); end
        a_fe_i = 1'b0;
        #1;
        checks++; if (a_fe_o !== 1'b0) begin errors++; $display("FAIL fetch_en_track0 got %b want 0", a_fe_o); end
        a_fe_i = 1'b1;
        #1;
        checks++; if (a_fe_o !== 1'b1) begin errors++; $display("FAIL fetch_en_track1 got %b want 1", a_fe_o); end
    endtask

    task automatic test_pad_mux();
        @(negedge clk);
        m_clk = 1'b1; m_csn = 1'b0; m_sdo = 4'hA; m_oen = 4'h0; a_sdi_ovr = 1'b1;
        #1;
        checks++; if ({a_sck, a_csn} !== 2'b10) begin errors++; $display("FAIL mux_clk_csn got %b want 10", {a_sck, a_csn}); end
        checks++; if (a_sdo !== 4'hA || a_oen !== 4'h0) begin errors++; $display("FAIL mux_sdo_oen got %h %h want a 0", a_sdo, a_oen); end
        checks++; if (a_msdi !== 4'h5) begin errors++; $display("FAIL mux_m_sdi got %h want 5", a_msdi); end
        m_clk = 1'b0; m_csn = 1'b1; m_sdo = 4'h3; m_oen = 4'hC; a_sdi_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({a_sck, a_csn, a_sdo, a_oen} !== {1'b0, 1'b1, 4'h3, 4'hC}) begin errors++; $display("FAIL mux_second got %b %b %h %h want 0 1 3 c", a_sck, a_csn, a_sdo, a_oen); end
        checks++; if (a_msdi !== a_sdi) begin errors++; $display("FAIL mux_m_sdi2 got %h want %h", a_msdi, a_sdi); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL done_sticky got %b want 1", a_done); end
    endtask

    initial begin
        int hdr_base;
        test_reset();
        test_clkdiv1();
        test_restart();
        hdr_base = g_fm[0].hdr_cnt;
        test_copy(hdr_base);
        test_fetch_en();
        test_pad_mux();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
